// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_arbiter                                                     |
// | Purpose  : Round-robin arbiter sharing one ALU593 between NREQ requesters. |
// |            Captures the winner's operands/opcode, runs the ALU start/done  |
// |            handshake and returns the 16-bit result with a one-cycle pulse. |
// | Ports    : clk, reset (async, active-high)                                 |
// |            req[NREQ], req_A/req_B[NREQ*8], req_op[NREQ]  - requesters      |
// |            gnt, rsp_valid (one-hot pulses), rsp_result, rsp_err, busy      |
// |            start, A, B, op (to ALU); alu_done, alu_result (from ALU)       |
// | Options  : ALU_ARB_TIMEOUT_EN - abort an operation after TIMEOUT BUSY      |
// |            cycles without alu_done (response flagged with rsp_err).        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

package tinyalu_pkg;
    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } alu_opcode_t;
endpackage

module alu_arbiter
    import tinyalu_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*8-1:0]      req_A,
    input  logic [NREQ*8-1:0]      req_B,
    input  alu_opcode_t [NREQ-1:0] req_op,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [15:0]            rsp_result,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   start,
    output logic [7:0]             A,
    output logic [7:0]             B,
    output alu_opcode_t            op,
    input  logic                   alu_done,
    input  logic [15:0]            alu_result
);

    localparam int                 c_PTR_W    = $clog2(NREQ);
    localparam logic [c_PTR_W-1:0] c_LAST_RST = c_PTR_W'(NREQ - 1);

    if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1) begin : g_param_check
        $error("alu_arbiter: NREQ must be 2..4 and TIMEOUT must be >= 1");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state,      w_state_nxt;
    logic                 r_start,      w_start_nxt;
    logic [7:0]           r_A,          w_A_nxt;
    logic [7:0]           r_B,          w_B_nxt;
    alu_opcode_t          r_op,         w_op_nxt;
    logic [NREQ-1:0]      r_gnt,        w_gnt_nxt;
    logic [NREQ-1:0]      r_rsp_valid,  w_rsp_valid_nxt;
    logic [15:0]          r_rsp_result, w_rsp_result_nxt;
    logic                 r_rsp_err,    w_rsp_err_nxt;
    logic                 r_busy,       w_busy_nxt;
    logic [c_PTR_W-1:0]   r_last,       w_last_nxt;
    logic [c_PTR_W-1:0]   r_owner,      w_owner_nxt;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int                 c_CNT_W = $clog2(TIMEOUT + 1);
    // Compared before incrementing, so the TIMEOUT-th BUSY cycle sees TIMEOUT-1.
    localparam logic [c_CNT_W-1:0] c_TMAX  = c_CNT_W'(TIMEOUT - 1);
    logic [c_CNT_W-1:0]   r_tcnt,       w_tcnt_nxt;
`endif

    // Round-robin search starting just after the last winner.
    logic                 w_found;
    logic [c_PTR_W-1:0]   w_winner;
    logic [c_PTR_W-1:0]   w_idx_p;
    int                   w_idx;
    logic [NREQ-1:0]      w_oh_win;
    logic [NREQ-1:0]      w_oh_own;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        w_idx_p  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = int'(r_last) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            w_idx_p = c_PTR_W'(w_idx);
            if (!w_found && req[w_idx_p]) begin
                w_found  = 1'b1;
                w_winner = w_idx_p;
            end
        end
        w_oh_win           = '0;
        w_oh_win[w_winner] = 1'b1;
        w_oh_own           = '0;
        w_oh_own[r_owner]  = 1'b1;
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_start_nxt      = r_start;
        w_A_nxt          = r_A;
        w_B_nxt          = r_B;
        w_op_nxt         = r_op;
        w_gnt_nxt        = '0;
        w_rsp_valid_nxt  = '0;
        w_rsp_result_nxt = r_rsp_result;
        w_rsp_err_nxt    = r_rsp_err;
        w_busy_nxt       = r_busy;
        w_last_nxt       = r_last;
        w_owner_nxt      = r_owner;
`ifdef ALU_ARB_TIMEOUT_EN
        w_tcnt_nxt       = r_tcnt;
`endif
        case (r_state)
            S_IDLE: begin
                w_start_nxt = 1'b0;
                if (w_found) begin
                    w_A_nxt     = req_A[{w_winner, 3'b000} +: 8];
                    w_B_nxt     = req_B[{w_winner, 3'b000} +: 8];
                    w_op_nxt    = req_op[w_winner];
                    w_start_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_gnt_nxt   = w_oh_win;
                    w_owner_nxt = w_winner;
                    w_last_nxt  = w_winner;
                    w_state_nxt = S_BUSY;
`ifdef ALU_ARB_TIMEOUT_EN
                    w_tcnt_nxt  = '0;
`endif
                end
            end
            S_BUSY: begin
                if (alu_done) begin
                    w_start_nxt      = 1'b0;
                    w_busy_nxt       = 1'b0;
                    w_rsp_result_nxt = alu_result;
                    w_rsp_valid_nxt  = w_oh_own;
                    w_rsp_err_nxt    = 1'b0;
                    w_state_nxt      = S_IDLE;
                end
`ifdef ALU_ARB_TIMEOUT_EN
                else if (r_tcnt == c_TMAX) begin
                    w_start_nxt      = 1'b0;
                    w_busy_nxt       = 1'b0;
                    w_rsp_result_nxt = 16'h0000;
                    w_rsp_valid_nxt  = w_oh_own;
                    w_rsp_err_nxt    = 1'b1;
                    w_state_nxt      = S_IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_start      <= 1'b0;
            r_A          <= '0;
            r_B          <= '0;
            r_op         <= no_op;
            r_gnt        <= '0;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_last       <= c_LAST_RST;
            r_owner      <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
            r_tcnt       <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_start      <= w_start_nxt;
            r_A          <= w_A_nxt;
            r_B          <= w_B_nxt;
            r_op         <= w_op_nxt;
            r_gnt        <= w_gnt_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_result <= w_rsp_result_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
            r_busy       <= w_busy_nxt;
            r_last       <= w_last_nxt;
            r_owner      <= w_owner_nxt;
`ifdef ALU_ARB_TIMEOUT_EN
            r_tcnt       <= w_tcnt_nxt;
`endif
        end
    end

    assign start      = r_start;
    assign A          = r_A;
    assign B          = r_B;
    assign op         = r_op;
    assign gnt        = r_gnt;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;
    assign busy       = r_busy;

endmodule

`default_nettype wire
